bus_drive_arbiter: RTL

BUS_DRIVE_ARBITER -- requirements
Module: bus_drive_arbiter

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 29 ++
 rtl/bus_drive_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and default constants for the bus drive arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StTurn
  } arb_state_e;

  localparam int unsigned DefaultN          = 4;
  localparam int unsigned DefaultTurnaround = 1;
  localparam int unsigned DefaultMaxHold    = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping at N-1.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] winner
);

  localparam int unsigned IdxW = $clog2(N);

  int unsigned idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner arbiter for a shared net, with all-off turnaround between owners
// and a hold limit that only bites when another requester is waiting.
module bus_drive_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N          = DefaultN,
  parameter int unsigned TURNAROUND = DefaultTurnaround,
  parameter int unsigned MAX_HOLD   = DefaultMaxHold
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TurnW = $clog2(TURNAROUND + 1);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [TurnW-1:0] turn_q, turn_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IdxW-1:0]  winner;
  logic             hold_full;
  logic             others_waiting;

  rr_picker #(
    .N (N)
  ) u_rr_picker (
    .req    (req),
    .ptr    (ptr_q),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign hold_full      = (hold_q == HoldW'(MAX_HOLD));
  assign others_waiting = |(req & ~grant_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StOwn;
          hold_d  = HoldW'(1);
        end
      end
      StOwn: begin
        if (!req[owner_q] || (hold_full && others_waiting)) begin
          state_d = StTurn;
          turn_d  = TurnW'(1);
          hold_d  = '0;
          ptr_d   = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + 1'b1;
        end else if (!hold_full) begin
          hold_d = hold_q + 1'b1;
        end
      end
      StTurn: begin
        if (turn_q == TurnW'(TURNAROUND)) begin
          turn_d = '0;
          if (found) begin
            state_d = StOwn;
            hold_d  = HoldW'(1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they appear registered on the same edge.
  always_comb begin
    grant_d = '0;
    owner_d = owner_q;
    busy_d  = 1'b0;
    if (state_d == StOwn) begin
      busy_d = 1'b1;
      if (state_q == StOwn) begin
        grant_d = grant_q;
      end else begin
        grant_d[winner] = 1'b1;
        owner_d         = winner;
      end
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
